// File: rtl/icache_assoc_pkg.sv
// Shared types and AXI encodings for the instruction cache.
package icache_assoc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    TRANS,
    RESP
  } state_e;

  localparam logic [1:0] INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

endpackage

// File: rtl/icache_assoc_way.sv
// One cache way: valid bits (reset), tag and data arrays (no reset).
// Lookup and refill share the index of the request being served.
module icache_way
  import icache_assoc_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int SET_NUM     = 8,
  parameter int TAG_W       = 25,
  parameter int IDX_W       = 3,
  parameter int WRD_W       = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [WRD_W-1:0] word_i,
  output logic             valid_o,
  output logic             hit_o,
  output logic [31:0]      rdata_o,
  input  logic             inval_i,
  input  logic             data_we_i,
  input  logic [WRD_W-1:0] wr_word_i,
  input  logic [31:0]      wr_data_i,
  input  logic             tag_we_i
);

  logic [SET_NUM-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [SET_NUM];
  logic [31:0]        data_q [SET_NUM][BLOCK_WORDS];

  // Valid bits: flush clears all, a completed fill sets, refill start clears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[index_i] <= 1'b1;
    end else if (inval_i) begin
      valid_q[index_i] <= 1'b0;
    end
  end

  // Tag and data storage, written only during a refill.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) tag_q[index_i] <= tag_i;
    if (data_we_i) data_q[index_i][wr_word_i] <= wr_data_i;
  end

  assign valid_o = valid_q[index_i];
  assign hit_o   = valid_q[index_i] && (tag_q[index_i] == tag_i);
  assign rdata_o = data_q[index_i][word_i];

endmodule

// File: rtl/icache_assoc.sv
// Read-only set-associative instruction cache with an AXI read master.
// Optional macro ICACHE_PERF_EN adds hit/miss event counters.
//
// state | meaning
// IDLE  | ready for a request, or clearing lines on flush
// CHECK | tag compare on the latched address
// REQ   | refill burst address issued downstream
// TRANS | collecting refill beats into the victim line
// RESP  | returning one beat upstream (loads, then waits for rready)
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int SET_NUM     = 8,
  parameter int WAY_NUM     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_arvalid_i,
  output logic        in_arready_o,
  input  logic [31:0] in_araddr_i,
  input  logic [3:0]  in_arid_i,
  input  logic [7:0]  in_arlen_i,
  input  logic [2:0]  in_arsize_i,
  input  logic [1:0]  in_arburst_i,
  input  logic        in_rready_i,
  output logic        in_rvalid_o,
  output logic [1:0]  in_rresp_o,
  output logic [31:0] in_rdata_o,
  output logic        in_rlast_o,
  output logic [3:0]  in_rid_o,
  output logic        out_arvalid_o,
  input  logic        out_arready_i,
  output logic [31:0] out_araddr_o,
  output logic [3:0]  out_arid_o,
  output logic [7:0]  out_arlen_o,
  output logic [2:0]  out_arsize_o,
  output logic [1:0]  out_arburst_o,
  output logic        out_rready_o,
  input  logic        out_rvalid_i,
  input  logic [1:0]  out_rresp_i,
  input  logic [31:0] out_rdata_i,
  input  logic        out_rlast_i,
  input  logic [3:0]  out_rid_i,
  input  logic        flush_i,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o
);

  localparam int OFF_W = $clog2(BLOCK_WORDS * 4);
  localparam int IDX_W = $clog2(SET_NUM);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int WRD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  state_e            state_q, state_d;
  logic [31:0]       addr_q;
  logic [3:0]        id_q;
  logic              way_sel_q, err_q, rvalid_q;
  logic [WRD_W-1:0]  beat_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic accept, flush_clr, check_hit, check_miss, ar_done, beat_we, fill_end, fill_ok;
  logic resp_load, resp_done;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WRD_W-1:0]  req_word;
  logic [1:0]        hit_w, valid_w;
  logic [31:0]       data_w [2];
  logic              any_hit, hit_way, victim, lru_bit;
  logic [31:0]       way_data;
  logic              unused_ok;

  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[31 -: TAG_W];
  assign req_word = (BLOCK_WORDS > 1) ? addr_q[2 +: WRD_W] : '0;
  assign any_hit  = |hit_w;
  assign hit_way  = hit_w[1];
  assign victim   = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_bit);
  assign way_data = way_sel_q ? data_w[1] : data_w[0];
  assign fill_ok  = fill_end && !err_q && (out_rresp_i == OKAY);
  assign unused_ok = ^{in_arlen_i, in_arsize_i, in_arburst_i, out_rid_i, addr_q[1:0]};

  // Next-state and per-state control strobes.
  always_comb begin
    state_d      = state_q;
    in_arready_o = 1'b0;
    accept       = 1'b0;
    flush_clr    = 1'b0;
    check_hit    = 1'b0;
    check_miss   = 1'b0;
    ar_done      = 1'b0;
    beat_we      = 1'b0;
    fill_end     = 1'b0;
    resp_load    = 1'b0;
    resp_done    = 1'b0;
    case (state_q)
      IDLE: begin
        in_arready_o = !flush_i;
        if (flush_i) begin
          flush_clr = 1'b1;
        end else if (in_arvalid_i) begin
          accept  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (any_hit) begin
          check_hit = 1'b1;
          state_d   = RESP;
        end else begin
          check_miss = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (out_arready_i) begin
          ar_done = 1'b1;
          state_d = TRANS;
        end
      end
      TRANS: begin
        if (out_rvalid_i) begin
          beat_we = 1'b1;
          if (out_rlast_i) begin
            fill_end = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (!rvalid_q) begin
          resp_load = 1'b1;
        end else if (in_rready_i) begin
          resp_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus request, refill and response bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      way_sel_q <= 1'b0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= in_araddr_i;
        id_q   <= in_arid_i;
        err_q  <= 1'b0;
      end
      if (check_hit)  way_sel_q <= hit_way;
      if (check_miss) way_sel_q <= victim;
      if (ar_done)    beat_q <= '0;
      if (beat_we) begin
        beat_q <= beat_q + 1'b1;
        if (out_rresp_i != OKAY) err_q <= 1'b1;
      end
      if (resp_load) begin
        rvalid_q <= 1'b1;
        rresp_q  <= err_q ? SLVERR : OKAY;
        rdata_q  <= err_q ? 32'h0 : way_data;
      end
      if (resp_done) rvalid_q <= 1'b0;
    end
  end

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    icache_way #(
      .BLOCK_WORDS(BLOCK_WORDS),
      .SET_NUM    (SET_NUM),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .WRD_W      (WRD_W)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (flush_clr),
      .index_i  (idx),
      .tag_i    (tag),
      .word_i   (req_word),
      .valid_o  (valid_w[w]),
      .hit_o    (hit_w[w]),
      .rdata_o  (data_w[w]),
      .inval_i  (ar_done && (way_sel_q == 1'(w))),
      .data_we_i(beat_we && (way_sel_q == 1'(w))),
      .wr_word_i(beat_q),
      .wr_data_i(out_rdata_i),
      .tag_we_i (fill_ok && (way_sel_q == 1'(w)))
    );
  end

  if (WAY_NUM == 1) begin : g_dm
    // Phantom second way: never hits and always looks occupied.
    assign hit_w[1]   = 1'b0;
    assign valid_w[1] = 1'b1;
    assign data_w[1]  = '0;
    assign lru_bit    = 1'b0;
  end else begin : g_lru
    logic [SET_NUM-1:0] lru_q;
    // Per-set LRU bit names the way to evict next.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lru_q <= '0;
      end else if (flush_clr) begin
        lru_q <= '0;
      end else if (check_hit) begin
        lru_q[idx] <= ~hit_way;
      end else if (fill_ok) begin
        lru_q[idx] <= ~way_sel_q;
      end
    end
    assign lru_bit = lru_q[idx];
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;
  // Lookup outcome counters, free-running and wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (check_hit)  perf_hit_q  <= perf_hit_q + 32'd1;
      if (check_miss) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end
  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`else
  assign perf_hit_o  = '0;
  assign perf_miss_o = '0;
`endif

  assign in_rvalid_o   = rvalid_q;
  assign in_rlast_o    = rvalid_q;
  assign in_rid_o      = id_q;
  assign in_rdata_o    = rdata_q;
  assign in_rresp_o    = rresp_q;
  assign out_arvalid_o = (state_q == REQ);
  assign out_araddr_o  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign out_arid_o    = '0;
  assign out_arlen_o   = 8'(BLOCK_WORDS - 1);
  assign out_arsize_o  = SIZE_4B;
  assign out_arburst_o = INCR;
  assign out_rready_o  = (state_q == TRANS);

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4, 32-bit words per block (power of 2, 1..16).
REQ-002 SHALL have parameter SET_NUM, default 8, sets per way (power of 2, >=2).
REQ-003 SHALL have parameter WAY_NUM, default 2, associativity (1 or 2).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_ar*  upstream AXI read-address channel: arvalid/arready 1, araddr 32, arid 4, arlen 8, arsize 3, arburst 2.
REQ-007 in_r*  upstream read-data channel: rready in 1; rvalid 1, rresp 2, rdata 32, rlast 1, rid 4 out.
REQ-008 out_ar*/out_r*  downstream AXI read master, same field widths, directions mirrored.
REQ-009 flush  in  1  invalidate all lines (fence.i).
REQ-010 perf_hit, perf_miss  out  32 each  event counters (see Configuration).

Function
REQ-011 States SHALL be IDLE, CHECK, REQ, TRANS, RESP.
REQ-012 in_arready SHALL be 1 only in IDLE with flush low; accepted request latches araddr and arid; IDLE->CHECK.
REQ-013 Only single-beat upstream requests SHALL be served; arlen/arsize/arburst ignored, araddr[1:0] ignored.
REQ-014 Address split: offset = log2(BLOCK_WORDS*4) bits, index = log2(SET_NUM) bits, tag = remainder.
REQ-015 CHECK: hit if any way valid with matching tag; hit -> RESP, miss -> REQ.
REQ-016 Hit latency SHALL be 2 cycles: accept at edge T, in_rvalid high after edge T+2.
REQ-017 RESP: in_rvalid=1, in_rlast=1, in_rid=latched arid, rresp=latched status; held stable until in_rready; handshake -> IDLE.
REQ-018 REQ: out_arvalid=1, out_araddr block-aligned, out_arlen=BLOCK_WORDS-1, out_arsize=2, out_arburst=INCR, out_arid=0; held until out_arready; then TRANS.
REQ-019 TRANS: out_rready=1; each beat written to word (beat count) of victim line; beat counter wraps only by reset/new refill.
REQ-020 On out_rlast beat with all beats OKAY: victim tag written, valid set, state RESP, requested word returned, rresp=OKAY.
REQ-021 Any beat with rresp!=OKAY: line SHALL stay invalid, burst drained to rlast, RESP returns rresp=SLVERR (2'b10), data 0.
REQ-022 Victim: invalid way first (way 0 before way 1), else LRU way; per-set LRU bit updated on every hit and refill to mark other way.
REQ-023 WAY_NUM=1: direct-mapped, LRU logic absent.
REQ-024 flush high in IDLE SHALL clear all valid and LRU bits next edge; flush outside IDLE SHALL be ignored (caller holds it).
REQ-025 Cache SHALL never issue writes; no write channel.

Reset
REQ-026 rst SHALL immediately force: state IDLE, all valid bits 0, LRU 0, in_rvalid 0, out_arvalid 0, beat counter 0, perf counters 0.
REQ-027 Reset mid-refill SHALL abandon the burst; tag/data arrays need no reset.

Configuration
REQ-028 Macro ICACHE_PERF_EN: defined -> perf_hit/perf_miss increment once per CHECK hit/miss, wrap at 2^32; undefined -> both tied 0, no counter flops.

Structure
REQ-029 Shared package SHALL hold state enum, AXI burst/size/resp constants (INCR, SIZE_4B, OKAY, SLVERR).
REQ-030 One sub-module icache_way (tag/valid/data array per way with read index, hit output, refill write port), instantiated WAY_NUM times.

Verification
REQ-031 Cold read 0x8000_0004 -> miss, out_araddr 0x8000_0000, arlen 3; beats 11,22,33,44 -> rdata 0x22, perf_miss=1.
REQ-032 Repeat 0x8000_0008 -> hit, rvalid 2 cycles after accept, rdata 0x33, no out_arvalid, perf_hit=1.
REQ-033 Fill 0x8000_0000, 0x8000_0080, read 0x8000_0000, then 0x8000_0100 (same set) -> evicts 0x80 line; 0x8000_0000 still hits.
REQ-034 in_rready held low 5 cycles -> rvalid/rdata/rid stable; completion only after rready.
REQ-035 Beat 2 returns SLVERR -> upstream rresp 2'b10; re-read same address misses again.
REQ-036 flush after fills -> next access to each line misses; rst asserted during TRANS -> outputs idle immediately, next request misses.
